// File: rtl/throughout_goto_monitor.sv
// Multi-channel checker for $rose(a) |=> (b throughout c[->N]) with a programmable N.
// Reports pass/fail pulses, sticky fail flags and a saturating total fail count.

module throughout_goto_chan #(
    parameter int CW        = 4,
    parameter int RETRIGGER = 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          a,
    input  logic          b,
    input  logic          c,
    input  logic [CW-1:0] count_cfg,
    output logic          active,
    output logic          pass,
    output logic          fail
);
    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] n_q, n_nx, cnt_q, cnt_nx;
    logic          a_prev, arm, done, pass_nx, fail_nx;

    // A rise with count_cfg == 0 never opens a window
    assign arm = a & ~a_prev & (count_cfg != '0);

    always_comb begin
        state_nx = state;
        n_nx     = n_q;
        cnt_nx   = cnt_q;
        pass_nx  = 1'b0;
        fail_nx  = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (arm) begin
                    state_nx = ACTIVE;
                    n_nx     = count_cfg;
                    cnt_nx   = '0;
                end
            end
            ACTIVE: begin
                if (!b) begin
                    fail_nx = 1'b1;
                    done    = 1'b1;
                end else if (c && (cnt_q + CW'(1)) == n_q) begin
                    pass_nx = 1'b1;
                    done    = 1'b1;
                end else if (c) begin
                    cnt_nx = cnt_q + CW'(1);
                end
                if (done) state_nx = IDLE;
                // Ending cycle always re-arms; a mid-window rise restarts only when retrigger is on
                if (arm && (done || RETRIGGER != 0)) begin
                    state_nx = ACTIVE;
                    n_nx     = count_cfg;
                    cnt_nx   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            n_q    <= '0;
            cnt_q  <= '0;
            a_prev <= 1'b0;
            active <= 1'b0;
            pass   <= 1'b0;
            fail   <= 1'b0;
        end else begin
            state  <= state_nx;
            n_q    <= n_nx;
            cnt_q  <= cnt_nx;
            a_prev <= a;
            active <= (state == ACTIVE);
            pass   <= pass_nx;
            fail   <= fail_nx;
        end
    end
endmodule

module throughout_goto_monitor #(
    parameter int NCH       = 4,
    parameter int CW        = 4,
    parameter int RETRIGGER = 1,
    parameter int FCW       = 16
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [NCH-1:0] a,
    input  logic [NCH-1:0] b,
    input  logic [NCH-1:0] c,
    input  logic [CW-1:0]  count_cfg,
    input  logic           clear_sticky,
    output logic [NCH-1:0] active,
    output logic [NCH-1:0] pass,
    output logic [NCH-1:0] fail,
    output logic [NCH-1:0] fail_sticky,
    output logic [FCW-1:0] fail_count
);
    logic [FCW:0] sum;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        throughout_goto_chan #(.CW(CW), .RETRIGGER(RETRIGGER)) u_ch (
            .clock     (clock),
            .reset     (reset),
            .a         (a[i]),
            .b         (b[i]),
            .c         (c[i]),
            .count_cfg (count_cfg),
            .active    (active[i]),
            .pass      (pass[i]),
            .fail      (fail[i])
        );
    end

    // Clear first, then add this cycle's fails; one spare bit flags overflow
    always_comb begin
        sum = clear_sticky ? '0 : {1'b0, fail_count};
        for (int i = 0; i < NCH; i++) sum = sum + (FCW + 1)'(fail[i]);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fail_sticky <= '0;
            fail_count  <= '0;
        end else begin
            fail_sticky <= (clear_sticky ? '0 : fail_sticky) | fail;
            fail_count  <= sum[FCW] ? '1 : sum[FCW-1:0];
        end
    end
endmodule

// File: doc/throughout_goto_monitor.md
Name: throughout_goto_monitor

Overview:
- Synthesizable, multi-channel hardware checker for the temporal property "after a rises, b holds throughout N occurrences of c", i.e. $rose(a) |=> (b throughout c[->N]).
- N is runtime-programmable.
- Retrigger policy is selectable.
- Pass and fail events, sticky failure flags and a saturating failure counter are reported.
- Sits alongside the seq-driven demo benches as a formal/simulation cross-check, and can also be used as an on-chip protocol monitor.

Parameters:
- NCH, 4: number of independent monitor channels.
- CW, 4: width of count_cfg and of each per-channel occurrence counter.
- RETRIGGER, 1: 1 = $rose(a) during an active window restarts it; 0 = $rose(a) during an active window is ignored.
- FCW, 16: width of fail_count.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous active-high reset; clears all state (equivalent to disable iff)
- a  input  NCH  per-channel trigger
- b  input  NCH  per-channel condition that must hold throughout the window
- c  input  NCH  per-channel counted event
- count_cfg  input  CW  required number of c occurrences N; sampled per channel at arm time
- clear_sticky  input  1  synchronous clear of fail_sticky and fail_count
- active  output  NCH  channel window open
- pass  output  NCH  one-cycle pulse: window completed with b held
- fail  output  NCH  one-cycle pulse: b low inside window
- fail_sticky  output  NCH  set by fail, held until clear_sticky or reset
- fail_count  output  FCW  total fail pulses across all channels, saturating

Behaviour:
- Reset values: all outputs 0; a_prev 0; counters 0; all channels IDLE. Reset mid-window aborts the window silently, with no pass and no fail.
- Edge detect: rose_i = a[i] & ~a_prev[i]. a_prev is registered every cycle, including while active.
- Per-channel FSM has two states, IDLE and ACTIVE.
- IDLE -> ACTIVE: on rose_i with count_cfg != 0. On that edge, latch N_i = count_cfg and set cnt_i = 0. The rose cycle itself is not evaluated; evaluation begins the next cycle (|=> semantics). rose_i with count_cfg == 0 is ignored.
- Evaluation, in each ACTIVE cycle, priority in this order:
  - b[i] == 0: window ends, fail pulse, go to IDLE. Fail wins even if c[i] is high in the same cycle.
  - b[i] == 1 and c[i] == 1 and cnt_i + 1 == N_i: window ends, pass pulse, go to IDLE.
  - b[i] == 1 and c[i] == 1 otherwise: cnt_i increments.
  - b[i] == 1 and c[i] == 0: hold.
- Non-consecutive c are counted (goto semantics). A c in the first evaluation cycle counts.
- Retrigger, for rose_i in a cycle where the channel is ACTIVE:
  - If the window ends in that same cycle (pass or fail), the ending event is reported and the channel re-arms (ACTIVE next cycle, cnt = 0, new N latched). This applies in both modes.
  - Otherwise, with RETRIGGER = 1: that cycle is still evaluated for the old window (b checked, any c dropped), then cnt resets to 0 and N is re-latched. This gives pass/fail equivalent to the union of overlapping SVA attempts.
  - Otherwise, with RETRIGGER = 0: rose_i is ignored.
- Output timing: pass, fail and active are registered; latency 1 cycle after the evaluated sample. active is high for exactly the evaluation cycles shifted by one.
- Sticky and counter:
  - fail_sticky[i] sets on fail[i].
  - fail_count adds popcount(fail) each cycle and saturates at 2^FCW - 1.
  - If clear_sticky coincides with new fails, the clear applies first, then that cycle's fails are recorded.
- Width rules: N_i range 1..2^CW - 1; cnt_i never exceeds N_i - 1.
- Channels are fully independent; there is no cross-channel priority.

Test Plan:
- Baseline (NCH = 1, N = 3):
  - Stimulus: a rises at cycle 1; b high cycles 2-15; c at cycles 2, 3, 5.
  - Required: pass pulse at cycle 6, no fail, active high for cycles 3-6.
- b dropout:
  - Stimulus: as baseline, but b low at cycle 4.
  - Required: fail at cycle 5, fail_sticky = 1, fail_count = 1, no pass.
- Fail priority and edge values:
  - Fail priority: b low in the same cycle as the 3rd c -> fail, not pass.
  - N = 1: c in the first evaluation cycle -> pass 1 cycle later.
  - count_cfg = 0 at the a rise -> the channel never arms.
- Retrigger modes (N = 2):
  - Stimulus: a rises at 1, c at 3, a re-rises at 4, c at 6 and 8, b high throughout.
  - Required with RETRIGGER = 1: pass at 9.
  - Required with RETRIGGER = 0: pass at 7, no second window.
- Simultaneous end and re-arm:
  - Stimulus: rose(a) in the same cycle as a completing c.
  - Required: pass reported, and a new window active the next cycle.
- Reset, clear and saturation:
  - Assert reset mid-window -> no pass or fail, all outputs 0.
  - 4 channels failing in the same cycle -> fail_count += 4.
  - Count to saturation with FCW = 3 -> holds at 7.
  - clear_sticky coinciding with 1 fail -> count = 1.
